vga_mode_ctrl: RTL and testbench
================================

# vga_mode_ctrl

Run-time video-mode controller for the VGA timing generator. Accepts a mode-change request over a valid/ready handshake, waits for the current frame to finish, and holds the timing generator disabled for a settle interval. It then loads the new porch/sync/display values with a single write strobe and re-enables scanout. It sits between the register front end and the timing generator, replacing the fixed per-mode parameters with registered, switchable values.

## Interface
- `RESET_MODE`, 0: mode loaded after reset. 0=640x480, 1=800x600, 2=1024x768, 3=1366x768.
- `SETTLE_CYCLES`, 4: cycles the generator stays disabled before the load strobe. Legal range 1..15.
- `CNT_W`, 11: width of every timing value and of the counter inputs.

Ports:
- `clk_i`  in  1  pixel clock.
- `arstn_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  mode-change request.
- `req_mode_i`  in  2  requested mode.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `hcount_i`  in  CNT_W  horizontal counter from the timing generator.
- `vcount_i`  in  CNT_W  vertical counter from the timing generator.
- `tg_en_o`  out  1  timing generator enable.
- `tg_we_o`  out  1  timing value load strobe.
- `hd_o`, `hf_o`, `hr_o`, `hb_o`  out  CNT_W each  horizontal display, front porch, sync, back porch.
- `vd_o`, `vf_o`, `vr_o`, `vb_o`  out  CNT_W each  vertical equivalents.
- `h_pol_o`, `v_pol_o`  out  1 each  sync polarity, 1 = active-high.
- `active_mode_o`  out  2  mode currently loaded.
- `busy_o`  out  1  high in every state except RUN.
- `done_o`  out  1  one-cycle pulse when a request completes.

## Operation
- Mode values (display/front/sync/back; polarity):
  - mode 0: H 640/16/96/48, V 480/10/2/33; pol 0/0.
  - mode 1: H 800/40/128/88, V 600/1/4/23; pol 1/1.
  - mode 2: H 1024/24/136/160, V 768/3/6/29; pol 0/0.
  - mode 3: H 1366/70/143/213, V 768/3/3/24; pol 1/1.
- FSM states: INIT, RUN, WAIT_EOF, BLANK, LOAD, RESTART.
- INIT is the reset state:
  - `tg_en_o`=0, `tg_we_o`=1.
  - Timing outputs and `active_mode_o` hold the RESET_MODE values.
  - Next state is RESTART.
- RESTART: `tg_en_o`=1. Next state is RUN. `done_o`=1 only if entered from LOAD.
- RUN: `req_ready_o`=1. On accept:
  - Requested mode equal to `active_mode_o`: stay in RUN and pulse `done_o` on the next cycle. No blanking occurs.
  - Otherwise: latch `req_mode_i` into a pending register and go to WAIT_EOF.
- WAIT_EOF: stay until `hcount_i`==htotal-1 and `vcount_i`==vtotal-1, where the totals are the sums of the active mode's values. Then go to BLANK.
- BLANK: `tg_en_o`=0. A down-counter is loaded with SETTLE_CYCLES-1. Go to LOAD when the counter reaches 0.
- LOAD: one cycle.
  - `tg_we_o`=1.
  - Timing outputs, polarities and `active_mode_o` update to the pending mode at the edge entering LOAD. They are therefore valid while the strobe is high.
  - Next state is RESTART.
- Totals are computed at CNT_W+1 bits. Every defined mode fits in CNT_W=11 (max htotal 1792).

## Timing
- Reset values:
  - `tg_en_o`=0, `tg_we_o`=1, `req_ready_o`=0, `busy_o`=1, `done_o`=0.
  - Timing outputs, polarities and `active_mode_o` take the RESET_MODE values.
- After reset release: cycle 0 is INIT (we=1), cycle 1 is RESTART (en=1), cycle 2 is RUN (ready=1).
- Accept at cycle T (non-identical mode):
  - T+1 is WAIT_EOF. `req_ready_o` is 0 from T+1.
  - If the end-of-frame match occurs at cycle E, then E+1..E+SETTLE_CYCLES are BLANK.
  - E+SETTLE_CYCLES+1 is LOAD.
  - E+SETTLE_CYCLES+2 is RESTART, with `done_o` high.
  - E+SETTLE_CYCLES+3 is RUN.
- Identical-mode accept at T: `done_o` high at T+1 and `req_ready_o` stays 1.
- `req_valid_i` outside RUN is ignored. The requester must hold it until ready.
- `arstn_i` assertion in any state immediately forces the INIT outputs and discards the pending request.
- If the end-of-frame match occurs in the same cycle as an accept in RUN, it is not used. The controller waits for the next frame end.

## Structure
- Package `vga_mode_pkg` holds:
  - `vga_timing_t` struct: hd, hf, hr, hb, vd, vf, vr, vb, h_pol, v_pol.
  - A 4-entry constant array of `vga_timing_t` indexed by mode.
  - The FSM state enum.
  - Function `htotal`/`vtotal`.
- No sub-module. A single FSM plus the pending-mode and settle-counter registers.

## Test plan
- Reset with RESET_MODE=0 → `tg_we_o` high one cycle, `hd_o`=640, `vb_o`=33, `h_pol_o`=0. `tg_en_o` rises 1 cycle later and `req_ready_o` 2 cycles later.
- Request mode 1 mid-frame → `tg_en_o` stays 1 until `hcount_i`=799, `vcount_i`=524. Then there are 4 cycles of en=0 and one we pulse with `hd_o`=800, `vr_o`=4, `h_pol_o`=1. `done_o` pulses with en=1 and `active_mode_o`=1.
- Request mode 0 while in mode 0 → no en drop, no we pulse, `done_o` one cycle after the accept.
- `req_valid_i` held during BLANK with mode 3 → ignored. It is accepted in RUN, followed by a full switch with `hd_o`=1366 and htotal wait at 1791.
- `arstn_i` low during BLANK → immediate en=0, we=1 and RESET_MODE values. The pending mode is never loaded.
- End-of-frame match coincident with accept → switch happens at the next frame end, exactly one frame later.

Source files
------------

// File: rtl/vga_mode_pkg.sv
// vga_mode_pkg
// Shared definitions for the run-time VGA mode controller:
//   - vga_timing_t : one video mode's porch/sync/display values and polarities
//   - MODE_TABLE   : constant timing values for the four supported modes
//   - state_t      : controller FSM states
//   - htotal/vtotal: line and frame totals, one bit wider than the values
package vga_mode_pkg;

    localparam int TIMING_W = 11;

    typedef logic [TIMING_W-1:0] tval_t;
    typedef logic [TIMING_W:0]   total_t;

    typedef struct packed {
        tval_t hd;
        tval_t hf;
        tval_t hr;
        tval_t hb;
        tval_t vd;
        tval_t vf;
        tval_t vr;
        tval_t vb;
        logic  h_pol;
        logic  v_pol;
    } vga_timing_t;

    // Indexed by mode number: 0=640x480, 1=800x600, 2=1024x768, 3=1366x768
    localparam vga_timing_t MODE_TABLE [4] = '{
        '{11'd640,  11'd16, 11'd96,  11'd48,  11'd480, 11'd10, 11'd2, 11'd33, 1'b0, 1'b0},
        '{11'd800,  11'd40, 11'd128, 11'd88,  11'd600, 11'd1,  11'd4, 11'd23, 1'b1, 1'b1},
        '{11'd1024, 11'd24, 11'd136, 11'd160, 11'd768, 11'd3,  11'd6, 11'd29, 1'b0, 1'b0},
        '{11'd1366, 11'd70, 11'd143, 11'd213, 11'd768, 11'd3,  11'd3, 11'd24, 1'b1, 1'b1}
    };

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_WAIT_EOF,
        ST_BLANK,
        ST_LOAD,
        ST_RESTART
    } state_t;

    function automatic total_t htotal(input vga_timing_t t);
        return total_t'(t.hd) + total_t'(t.hf) + total_t'(t.hr) + total_t'(t.hb);
    endfunction

    function automatic total_t vtotal(input vga_timing_t t);
        return total_t'(t.vd) + total_t'(t.vf) + total_t'(t.vr) + total_t'(t.vb);
    endfunction

endpackage

// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl
// Run-time video-mode controller placed between the register front end and
// the VGA timing generator. A mode-change request is accepted in RUN, the
// controller waits for the current frame to end, holds the generator
// disabled for SETTLE_CYCLES, loads the new values with one write strobe and
// re-enables scanout.
//
// Ports:
//   clk_i, arstn_i             pixel clock, asynchronous active-low reset
//   req_valid_i/req_mode_i     mode-change request (valid/ready handshake)
//   req_ready_o                high only in RUN
//   hcount_i/vcount_i          counters from the timing generator
//   tg_en_o/tg_we_o            generator enable and timing load strobe
//   hd_o..vb_o                 timing values of the loaded mode
//   h_pol_o/v_pol_o            sync polarities (1 = active-high)
//   active_mode_o              mode currently loaded
//   busy_o                     high in every state except RUN
//   done_o                     one-cycle pulse when a request completes
module vga_mode_ctrl
    import vga_mode_pkg::*;
#(
    parameter int unsigned RESET_MODE    = 0,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 11
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             req_valid_i,
    input  logic [1:0]       req_mode_i,
    output logic             req_ready_o,
    input  logic [CNT_W-1:0] hcount_i,
    input  logic [CNT_W-1:0] vcount_i,
    output logic             tg_en_o,
    output logic             tg_we_o,
    output logic [CNT_W-1:0] hd_o,
    output logic [CNT_W-1:0] hf_o,
    output logic [CNT_W-1:0] hr_o,
    output logic [CNT_W-1:0] hb_o,
    output logic [CNT_W-1:0] vd_o,
    output logic [CNT_W-1:0] vf_o,
    output logic [CNT_W-1:0] vr_o,
    output logic [CNT_W-1:0] vb_o,
    output logic             h_pol_o,
    output logic             v_pol_o,
    output logic [1:0]       active_mode_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0]  RESET_IDX    = 2'(RESET_MODE);
    localparam vga_timing_t RESET_TIMING = MODE_TABLE[RESET_IDX];
    localparam logic [3:0]  SETTLE_LOAD  = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    vga_timing_t cur;
    logic [1:0]  active_mode;
    logic [1:0]  pending;
    logic [3:0]  settle_cnt;
    logic        from_load;
    logic        same_done;

    logic             accept;
    logic             same_mode;
    logic             eof;
    logic [CNT_W:0]   h_last;
    logic [CNT_W:0]   v_last;

    assign accept    = (state == ST_RUN) && req_valid_i;
    assign same_mode = (req_mode_i == active_mode);

    // Last pixel of the frame for the mode that is currently scanning out
    assign h_last = (CNT_W+1)'(htotal(cur)) - (CNT_W+1)'(1);
    assign v_last = (CNT_W+1)'(vtotal(cur)) - (CNT_W+1)'(1);
    assign eof    = ({1'b0, hcount_i} == h_last) && ({1'b0, vcount_i} == v_last);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cur         <= RESET_TIMING;
            active_mode <= RESET_IDX;
            settle_cnt  <= '0;
            from_load   <= 1'b0;
            same_done   <= 1'b0;
        end else begin
            from_load <= (state == ST_LOAD);
            same_done <= accept && same_mode;

            if (state == ST_WAIT_EOF && eof) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (state == ST_BLANK && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            // New values land on the edge entering LOAD so they are stable
            // for the whole strobe cycle.
            if (state == ST_BLANK && settle_cnt == 4'd0) begin
                cur         <= MODE_TABLE[pending];
                active_mode <= pending;
            end
        end
    end

    // Pending mode is only consumed after a fresh accept, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (accept && !same_mode) begin
            pending <= req_mode_i;
        end
    end

    always_comb begin
        state_nx    = state;
        tg_en_o     = 1'b0;
        tg_we_o     = 1'b0;
        req_ready_o = 1'b0;
        busy_o      = 1'b1;
        unique case (state)
            ST_INIT: begin
                tg_we_o  = 1'b1;
                state_nx = ST_RESTART;
            end
            ST_RESTART: begin
                tg_en_o  = 1'b1;
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                tg_en_o     = 1'b1;
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i && !same_mode) begin
                    state_nx = ST_WAIT_EOF;
                end
            end
            ST_WAIT_EOF: begin
                tg_en_o = 1'b1;
                if (eof) begin
                    state_nx = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (settle_cnt == 4'd0) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tg_we_o  = 1'b1;
                state_nx = ST_RESTART;
            end
            default: begin
                state_nx = ST_INIT;
            end
        endcase
    end

    assign done_o = ((state == ST_RESTART) && from_load) || same_done;

    assign hd_o          = CNT_W'(cur.hd);
    assign hf_o          = CNT_W'(cur.hf);
    assign hr_o          = CNT_W'(cur.hr);
    assign hb_o          = CNT_W'(cur.hb);
    assign vd_o          = CNT_W'(cur.vd);
    assign vf_o          = CNT_W'(cur.vf);
    assign vr_o          = CNT_W'(cur.vr);
    assign vb_o          = CNT_W'(cur.vb);
    assign h_pol_o       = cur.h_pol;
    assign v_pol_o       = cur.v_pol;
    assign active_mode_o = active_mode;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// tb_vga_mode_ctrl
// Randomized and directed stimulus for vga_mode_ctrl, checked every cycle
// against a timeline model of the mode-switch sequence, plus literal
// expectations at the key points of each directed scenario.
module tb_vga_mode_ctrl;

    localparam int RMODE  = 0;
    localparam int SETTLE = 4;
    localparam int W      = 11;

    logic         clk = 1'b0;
    logic         arstn;
    logic         req_valid;
    logic [1:0]   req_mode;
    logic         req_ready;
    logic [W-1:0] hcount;
    logic [W-1:0] vcount;
    logic         tg_en, tg_we;
    logic [W-1:0] hd, hf, hr, hb, vd, vf, vr, vb;
    logic         h_pol, v_pol;
    logic [1:0]   active_mode;
    logic         busy, done;

    vga_mode_ctrl #(
        .RESET_MODE   (RMODE),
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (W)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .req_valid_i  (req_valid),
        .req_mode_i   (req_mode),
        .req_ready_o  (req_ready),
        .hcount_i     (hcount),
        .vcount_i     (vcount),
        .tg_en_o      (tg_en),
        .tg_we_o      (tg_we),
        .hd_o         (hd),
        .hf_o         (hf),
        .hr_o         (hr),
        .hb_o         (hb),
        .vd_o         (vd),
        .vf_o         (vf),
        .vr_o         (vr),
        .vb_o         (vb),
        .h_pol_o      (h_pol),
        .v_pol_o      (v_pol),
        .active_mode_o(active_mode),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    // Mode tables written out from the mode list
    int HD [4] = '{640, 800, 1024, 1366};
    int HF [4] = '{16, 40, 24, 70};
    int HR [4] = '{96, 128, 136, 143};
    int HB [4] = '{48, 88, 160, 213};
    int VD [4] = '{480, 600, 768, 768};
    int VF [4] = '{10, 1, 3, 3};
    int VR [4] = '{2, 4, 6, 3};
    int VB [4] = '{33, 23, 29, 24};
    int HP [4] = '{0, 1, 0, 1};
    int VP [4] = '{0, 1, 0, 1};
    int HT [4] = '{800, 1056, 1344, 1792};
    int VT [4] = '{525, 628, 806, 798};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // boot: 0 = reset/first cycle, 1 = re-enable cycle, 2 = operational.
    // k: cycles since the end-of-frame match of a switch in progress (0 = none).
    int         boot      = 0;
    int         mmode     = RMODE;
    int         pend      = 0;
    int         k         = 0;
    bit         wait_eof  = 0;
    bit         same_done = 0;

    always @(negedge clk) begin
        int e_en, e_we, e_ready, e_done;
        bit sd_n;
        if (!arstn) begin
            boot = 0; mmode = RMODE; k = 0; wait_eof = 0; same_done = 0;
        end
        e_en    = (boot == 0) ? 0 : (boot == 1) ? 1 : ((k >= 1 && k <= SETTLE + 1) ? 0 : 1);
        e_we    = (boot == 0 || (boot == 2 && k == SETTLE + 1)) ? 1 : 0;
        e_ready = (boot == 2 && k == 0 && !wait_eof) ? 1 : 0;
        e_done  = (boot == 2 && (k == SETTLE + 2 || same_done)) ? 1 : 0;
        check("tg_en", int'(tg_en), e_en);
        check("tg_we", int'(tg_we), e_we);
        check("req_ready", int'(req_ready), e_ready);
        check("busy", int'(busy), 1 - e_ready);
        check("done", int'(done), e_done);
        check("active_mode", int'(active_mode), mmode);
        check("hd", int'(hd), HD[mmode]);
        check("hf", int'(hf), HF[mmode]);
        check("hr", int'(hr), HR[mmode]);
        check("hb", int'(hb), HB[mmode]);
        check("vd", int'(vd), VD[mmode]);
        check("vf", int'(vf), VF[mmode]);
        check("vr", int'(vr), VR[mmode]);
        check("vb", int'(vb), VB[mmode]);
        check("h_pol", int'(h_pol), HP[mmode]);
        check("v_pol", int'(v_pol), VP[mmode]);

        // advance to the next cycle using the inputs the DUT samples
        if (arstn) begin
            if (boot < 2) begin
                boot++;
            end else begin
                sd_n = 0;
                if (k == 0 && !wait_eof && req_valid) begin
                    if (int'(req_mode) == mmode) sd_n = 1;
                    else begin pend = int'(req_mode); wait_eof = 1; end
                end else if (wait_eof) begin
                    if (int'(hcount) == HT[mmode] - 1 && int'(vcount) == VT[mmode] - 1) begin
                        wait_eof = 0; k = 1;
                    end
                end else if (k > 0) begin
                    k++;
                    if (k == SETTLE + 1) mmode = pend;
                    if (k == SETTLE + 3) k = 0;
                end
                same_done = sd_n;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Counter values that can never form an end-of-frame match (v < 524)
    task automatic rand_counts();
        hcount = W'($urandom_range(0, 1000));
        vcount = W'($urandom_range(0, 400));
    endtask

    task automatic eof_counts(input int m);
        hcount = W'(HT[m] - 1);
        vcount = W'(VT[m] - 1);
    endtask

    task automatic request(input int m, input bit coincide);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_mode  = 2'(m);
        if (coincide) eof_counts(mmode);
        for (int n = 0; n <= 200; n++) begin
            @(negedge clk);
            if (req_ready) break;
            if (n == 200) check("ready_timeout", 0, 1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rand_counts();
    endtask

    task automatic eof_pulse(input int m);
        @(posedge clk); #1;
        eof_counts(m);
        @(posedge clk); #1;
        rand_counts();
    endtask

    task automatic wait_we();
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (tg_we) break;
            if (n == 40) check("we_timeout", 0, 1);
        end
    endtask

    task automatic wait_ready();
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (req_ready) break;
            if (n == 40) check("idle_timeout", 0, 1);
        end
    endtask

    initial begin
        arstn     = 1'b0;
        req_valid = 1'b0;
        req_mode  = 2'd0;
        rand_counts();

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", int'(tg_we), 1);
        check("rst_en", int'(tg_en), 0);
        check("rst_hd", int'(hd), 640);
        check("rst_vb", int'(vb), 33);
        check("rst_hpol", int'(h_pol), 0);
        check("rst_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        arstn = 1'b1;
        @(negedge clk); check("boot0_we", int'(tg_we), 1);
        @(negedge clk); check("boot1_en", int'(tg_en), 1);
        @(negedge clk); check("boot2_ready", int'(req_ready), 1);

        // mode 0 -> 1 mid-frame
        request(1, 0);
        repeat (5) @(posedge clk);
        eof_pulse(0);
        wait_we();
        check("m1_hd", int'(hd), 800);
        check("m1_vr", int'(vr), 4);
        check("m1_hpol", int'(h_pol), 1);
        @(negedge clk);
        check("m1_done", int'(done), 1);
        check("m1_en", int'(tg_en), 1);
        check("m1_mode", int'(active_mode), 1);
        wait_ready();

        // identical mode: done one cycle after accept, no blanking
        request(1, 0);
        @(negedge clk);
        check("same_done", int'(done), 1);
        check("same_ready", int'(req_ready), 1);
        check("same_en", int'(tg_en), 1);

        // request held through BLANK is only taken in RUN
        request(2, 0);
        eof_pulse(1);
        request(3, 0);
        eof_pulse(2);
        wait_we();
        check("m3_hd", int'(hd), 1366);
        wait_ready();
        request(0, 0);
        eof_pulse(3);
        wait_we();
        check("m0_hd", int'(hd), 640);
        wait_ready();

        // reset asserted during BLANK discards the pending mode
        request(1, 0);
        eof_pulse(0);
        @(posedge clk); #1;
        arstn = 1'b0;
        #1;
        check("arst_en", int'(tg_en), 0);
        check("arst_we", int'(tg_we), 1);
        check("arst_hd", int'(hd), 640);
        check("arst_mode", int'(active_mode), 0);
        @(posedge clk); #1;
        arstn = 1'b1;
        wait_ready();
        check("arst_kept", int'(active_mode), 0);

        // end-of-frame coincident with accept is not used
        request(2, 1);
        repeat (10) @(negedge clk);
        check("coinc_en", int'(tg_en), 1);
        check("coinc_mode", int'(active_mode), 0);
        eof_pulse(0);
        wait_we();
        check("coinc_hd", int'(hd), 1024);
        wait_ready();

        // random phase
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 3) == 0);
            req_mode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) eof_counts(mmode);
            else rand_counts();
            if ($urandom_range(0, 499) == 0) arstn = 1'b0;
            else arstn = 1'b1;
        end
        @(posedge clk); #1;
        arstn     = 1'b1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
